wash_phase_scheduler: RTL
=========================

Name: wash_phase_scheduler

Overview:
Timing and supervision companion to the washing-machine sequencing FSM. It turns the controller's phase activity into the timed events the FSM waits on:
- cycletime_out, from a programmable wash/rinse duration.
- spintime_out, from a programmable spin duration.
It also watches fill and drain durations and raises a sticky fault on timeout or illegal phase overlap. It sits between the program selector and the washing-machine FSM, one instance per machine.

Parameters:
TICK_DIV, 1000, clk cycles per timing tick (>=2)
CNT_W, 12, width of phase tick counter and of all length parameters
QUICK_WASH, 20, wash/rinse ticks for program 0
NORMAL_WASH, 40, wash/rinse ticks for program 1 (also used for program 3)
HEAVY_WASH, 60, wash/rinse ticks for program 2
QUICK_SPIN, 10, spin ticks for program 0
NORMAL_SPIN, 20, spin ticks for programs 1 and 3
HEAVY_SPIN, 30, spin ticks for program 2
FILL_LIMIT, 50, maximum fill ticks before fault
DRAIN_LIMIT, 50, maximum drain ticks before fault

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
prog_sel  in  2  program select, sampled only on prog_load
prog_load  in  1  1-cycle strobe: latch program, start session
fill_run  in  1  controller fill valve active
wash_run  in  1  controller motor active (wash or rinse)
drain_run  in  1  controller drain active (not spin)
spin_run  in  1  controller spin active
doorclose  in  1  door closed
done  in  1  controller end-of-session pulse
fault_clr  in  1  clears FAULT
cycletime_out  out  1  1-cycle pulse: wash/rinse time elapsed
spintime_out  out  1  1-cycle pulse: spin time elapsed
busy  out  1  session active (RUN or HOLD)
fault  out  1  sticky fault flag
fault_code  out  2  0 none, 1 fill timeout, 2 drain timeout, 3 phase overlap
remaining  out  CNT_W  ticks left in current wash/spin phase, else 0

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; prescaler, counter and latched lengths 0.
- States: IDLE, RUN, HOLD, FAULT.
- IDLE: prog_load=1 latches wash_len/spin_len from prog_sel and moves to RUN next edge. A latched length of 0 is forced to 1.
- prog_load outside IDLE is ignored.
- RUN, prescaler: counts 0..TICK_DIV-1 and wraps. tick=1 in the cycle the count equals TICK_DIV-1.
- RUN, phase: phase = one-hot {fill, wash, drain, spin} from inputs, registered each cycle.
- Phase counter:
  - Cleared to 0 and prescaler cleared on any change of registered phase (phase entry). The entry cycle does not count.
  - Increments on tick while a phase is active.
  - Saturates at 2^CNT_W-1.
- Wash: when tick occurs with counter==wash_len-1, cycletime_out=1 for exactly the next cycle (registered). Once per phase entry; re-armed by the next entry, so a rinse pass gets its own pulse.
- Spin: same rule with spin_len, driving spintime_out.
- Fill: counter reaching FILL_LIMIT → FAULT, code 1.
- Drain: counter reaching DRAIN_LIMIT → FAULT, code 2.
- Two or more run inputs high in the same cycle → FAULT, code 3. This check has priority over timeouts in the same cycle.
- remaining: len-counter during wash or spin; 0 otherwise, and 0 after the pulse.
- doorclose=0 in RUN → HOLD next edge. HOLD freezes prescaler, counter and phase register; no pulses are emitted. doorclose=1 → RUN, resuming the exact counts.
- done=1 in RUN or HOLD → IDLE: counters cleared, busy=0. done has priority over a simultaneous timeout, but not over overlap.
- FAULT: fault=1 and fault_code held; counters frozen; pulses suppressed. fault_clr=1 → IDLE with fault=0 and code=0. No other input leaves FAULT.
- busy=1 in RUN and HOLD only.
- Reset mid-session aborts immediately to the reset values.

Decomposition:
- Package wm_sched_pkg:
  - state enum (IDLE/RUN/HOLD/FAULT)
  - phase one-hot encoding
  - fault code constants
  - program code constants (QUICK=0, NORMAL=1, HEAVY=2, RSVD=3)
- One sub-module, wm_tick_prescaler: enable, clear, tick out, parameter TICK_DIV.

Test Plan:
- TICK_DIV=4, prog 0 with QUICK_WASH=3; wash_run held high → cycletime_out single pulse at 13th cycle after wash_run registers (12 counting cycles + register); remaining counts 3,2,1,0.
- Same, spin_run with QUICK_SPIN=2 → spintime_out pulse after 8+1 cycles. Drop and reassert wash_run → second cycletime_out after another 13 cycles.
- fill_run held, FILL_LIMIT=5, TICK_DIV=4 → fault=1, fault_code=1 after 20 counting cycles; fault_clr → IDLE, fault=0.
- wash_run and drain_run both high one cycle → fault_code=3 next edge, no cycletime_out.
- doorclose dropped at counter=2 for 10 cycles → counter and remaining frozen; pulse delayed by exactly 10 cycles.
- prog_sel=3 → NORMAL lengths latched. prog_load during RUN ignored. Reset asserted mid-spin → all outputs 0 asynchronously.

Source files
------------

// File: rtl/wash_phase_scheduler_pkg.sv
// Shared types and constants for the wash phase scheduler.
//   state_e      : session state (idle, run, door-open hold, fault)
//   phase_t      : one-hot registered phase {fill, wash, drain, spin}
//   fault_code_t : fault cause reported on fault_code
//   Prog*        : program select codes
package wm_sched_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StHold,
        StFault
    } state_e;

    typedef logic [3:0] phase_t;

    localparam phase_t PhNone  = 4'b0000;
    localparam phase_t PhFill  = 4'b1000;
    localparam phase_t PhWash  = 4'b0100;
    localparam phase_t PhDrain = 4'b0010;
    localparam phase_t PhSpin  = 4'b0001;

    typedef logic [1:0] fault_code_t;

    localparam fault_code_t FcNone    = 2'd0;
    localparam fault_code_t FcFill    = 2'd1;
    localparam fault_code_t FcDrain   = 2'd2;
    localparam fault_code_t FcOverlap = 2'd3;

    localparam logic [1:0] ProgQuick  = 2'd0;
    localparam logic [1:0] ProgNormal = 2'd1;
    localparam logic [1:0] ProgHeavy  = 2'd2;
    localparam logic [1:0] ProgRsvd   = 2'd3;

    // True when more than one bit is set (clearing the lowest set bit leaves something).
    function automatic logic multi_hot(input phase_t v);
        return (v & (v - 4'd1)) != 4'd0;
    endfunction

endpackage

// File: rtl/wash_phase_scheduler_if.sv
// Bus between the washing-machine controller and the phase scheduler.
//   controller -> scheduler : prog_sel, prog_load, fill_run, wash_run, drain_run, spin_run,
//                             doorclose, done, fault_clr
//   scheduler -> controller : cycletime_out, spintime_out, busy, fault, fault_code, remaining
// master = controller side, slave = scheduler side.
interface wash_phase_scheduler_if #(
    parameter int unsigned CNT_W = 12
);
    logic [1:0]       prog_sel;
    logic             prog_load;
    logic             fill_run;
    logic             wash_run;
    logic             drain_run;
    logic             spin_run;
    logic             doorclose;
    logic             done;
    logic             fault_clr;
    logic             cycletime_out;
    logic             spintime_out;
    logic             busy;
    logic             fault;
    logic [1:0]       fault_code;
    logic [CNT_W-1:0] remaining;

    modport master (
        output prog_sel, prog_load, fill_run, wash_run, drain_run, spin_run,
               doorclose, done, fault_clr,
        input  cycletime_out, spintime_out, busy, fault, fault_code, remaining
    );

    modport slave (
        input  prog_sel, prog_load, fill_run, wash_run, drain_run, spin_run,
               doorclose, done, fault_clr,
        output cycletime_out, spintime_out, busy, fault, fault_code, remaining
    );
endinterface

// File: rtl/wash_phase_scheduler_prescaler.sv
// Timing-tick prescaler: counts 0..TICK_DIV-1 while enabled and wraps.
//   clk, rst : clock, async active-low reset
//   en       : advance the count this cycle
//   clr      : return the count to 0 (wins over en)
//   tick     : high in an enabled cycle whose count is TICK_DIV-1
module wm_tick_prescaler #(
    parameter int unsigned TICK_DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int unsigned W = $clog2(TICK_DIV);
    localparam logic [W-1:0] Last = W'(TICK_DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == Last) ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && !clr && (cnt_q == Last);
endmodule

// File: rtl/wash_phase_scheduler.sv
// Phase timing and supervision for the washing-machine sequencer.
//   clk, rst : clock, async active-low reset
//   bus      : slave side of wash_phase_scheduler_if (program load, phase activity, door,
//              done, fault clear in; timed pulses, busy, fault, fault_code, remaining out)
// Wash/rinse and spin phases get a one-cycle elapsed pulse; fill and drain are bounded by
// timeouts; overlapping phase requests raise a sticky fault.
module wash_phase_scheduler
    import wm_sched_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 1000,
    parameter int unsigned CNT_W       = 12,
    parameter int unsigned QUICK_WASH  = 20,
    parameter int unsigned NORMAL_WASH = 40,
    parameter int unsigned HEAVY_WASH  = 60,
    parameter int unsigned QUICK_SPIN  = 10,
    parameter int unsigned NORMAL_SPIN = 20,
    parameter int unsigned HEAVY_SPIN  = 30,
    parameter int unsigned FILL_LIMIT  = 50,
    parameter int unsigned DRAIN_LIMIT = 50
) (
    input logic                  clk,
    input logic                  rst,
    wash_phase_scheduler_if.slave bus
);
    typedef logic [CNT_W-1:0] cnt_t;

    state_e      state_q, state_d;
    phase_t      phase_q, phase_d;
    cnt_t        cnt_q, cnt_d;
    cnt_t        wash_len_q, wash_len_d;
    cnt_t        spin_len_q, spin_len_d;
    fault_code_t code_q, code_d;
    logic        cyc_q, cyc_d;
    logic        spn_q, spn_d;

    // A zero-length phase would never match len-1, so it is stretched to one tick.
    function automatic cnt_t nonzero(input int unsigned v);
        return (v == 0) ? cnt_t'(1) : cnt_t'(v);
    endfunction

    cnt_t wash_sel, spin_sel;
    always_comb begin
        unique case (bus.prog_sel)
            ProgQuick: begin
                wash_sel = nonzero(QUICK_WASH);
                spin_sel = nonzero(QUICK_SPIN);
            end
            ProgHeavy: begin
                wash_sel = nonzero(HEAVY_WASH);
                spin_sel = nonzero(HEAVY_SPIN);
            end
            default: begin  // ProgNormal and ProgRsvd
                wash_sel = nonzero(NORMAL_WASH);
                spin_sel = nonzero(NORMAL_SPIN);
            end
        endcase
    end

    phase_t phase_in;
    logic   in_run, overlap, entry, psc_en, psc_clr, tick;
    cnt_t   cnt_inc;
    logic   wash_hit, spin_hit, fill_to, drain_to;

    assign phase_in = {bus.fill_run, bus.wash_run, bus.drain_run, bus.spin_run};
    assign in_run   = (state_q == StRun);
    assign overlap  = in_run && multi_hot(phase_in);
    assign entry    = in_run && (phase_in != phase_q);

    // Prescaler only runs on RUN cycles that keep the same phase; the entry cycle restarts it.
    assign psc_en  = in_run && !overlap && !bus.done && !entry;
    assign psc_clr = ((state_q == StIdle) && bus.prog_load)
                   || (in_run && !overlap && (bus.done || entry))
                   || ((state_q == StHold) && bus.done)
                   || ((state_q == StFault) && bus.fault_clr);

    wm_tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (psc_en),
        .clr  (psc_clr),
        .tick (tick)
    );

    assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + cnt_t'(1);
    assign wash_hit = tick && (phase_q == PhWash) && (cnt_q == wash_len_q - cnt_t'(1));
    assign spin_hit = tick && (phase_q == PhSpin) && (cnt_q == spin_len_q - cnt_t'(1));
    assign fill_to  = tick && (phase_q == PhFill) && (cnt_inc >= cnt_t'(FILL_LIMIT));
    assign drain_to = tick && (phase_q == PhDrain) && (cnt_inc >= cnt_t'(DRAIN_LIMIT));

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        wash_len_d = wash_len_q;
        spin_len_d = spin_len_q;
        code_d     = code_q;
        cyc_d      = 1'b0;
        spn_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.prog_load) begin
                    wash_len_d = wash_sel;
                    spin_len_d = spin_sel;
                    phase_d    = PhNone;
                    cnt_d      = '0;
                    state_d    = StRun;
                end
            end
            StRun: begin
                if (overlap) begin
                    state_d = StFault;
                    code_d  = FcOverlap;
                end else if (bus.done) begin
                    state_d = StIdle;
                    phase_d = PhNone;
                    cnt_d   = '0;
                end else begin
                    phase_d = phase_in;
                    if (entry) begin
                        cnt_d = '0;
                    end else if (tick && (phase_q != PhNone)) begin
                        cnt_d = cnt_inc;
                    end
                    if (fill_to) begin
                        state_d = StFault;
                        code_d  = FcFill;
                    end else if (drain_to) begin
                        state_d = StFault;
                        code_d  = FcDrain;
                    end else if (!bus.doorclose) begin
                        state_d = StHold;
                    end
                    // Pulses only leave while the session keeps running.
                    cyc_d = wash_hit && (state_d == StRun);
                    spn_d = spin_hit && (state_d == StRun);
                end
            end
            StHold: begin
                if (bus.done) begin
                    state_d = StIdle;
                    phase_d = PhNone;
                    cnt_d   = '0;
                end else if (bus.doorclose) begin
                    state_d = StRun;
                end
            end
            StFault: begin
                if (bus.fault_clr) begin
                    state_d = StIdle;
                    code_d  = FcNone;
                    phase_d = PhNone;
                    cnt_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            phase_q    <= PhNone;
            cnt_q      <= '0;
            wash_len_q <= '0;
            spin_len_q <= '0;
            code_q     <= FcNone;
            cyc_q      <= 1'b0;
            spn_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            wash_len_q <= wash_len_d;
            spin_len_q <= spin_len_d;
            code_q     <= code_d;
            cyc_q      <= cyc_d;
            spn_q      <= spn_d;
        end
    end

    cnt_t remaining;
    always_comb begin
        remaining = '0;
        if ((state_q == StRun) || (state_q == StHold)) begin
            if ((phase_q == PhWash) && (cnt_q < wash_len_q)) begin
                remaining = wash_len_q - cnt_q;
            end else if ((phase_q == PhSpin) && (cnt_q < spin_len_q)) begin
                remaining = spin_len_q - cnt_q;
            end
        end
    end

    assign bus.cycletime_out = cyc_q;
    assign bus.spintime_out  = spn_q;
    assign bus.busy          = (state_q == StRun) || (state_q == StHold);
    assign bus.fault         = (state_q == StFault);
    assign bus.fault_code    = code_q;
    assign bus.remaining     = remaining;
endmodule
